// File: rtl/pc_loop_sequencer.sv
// pc_loop_sequencer: run controller for an attached looping program counter.
// Latches a loop configuration, gates the PC enable pass by pass and flags valid/last/done.
//
// state | meaning
// IDLE  | PC held in reset, config accepted, waiting for start
// RUN   | PC enabled (unless stalled), passes counted
// FLUSH | final value issued, waiting for it to appear on pc
// DONE  | done pulse, PC back in reset
module pc_loop_sequencer #(
  parameter int PC_WIDTH   = 8,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [PC_WIDTH-1:0]   cfg_max,
  input  logic [PC_WIDTH-1:0]   cfg_loop,
  input  logic [ITER_WIDTH-1:0] cfg_iters,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  abort,
  output logic                  pc_rst,
  output logic                  pc_en,
  output logic [PC_WIDTH-1:0]   pc_max,
  output logic [PC_WIDTH-1:0]   pc_loop,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  pc_valid,
  output logic                  last,
  output logic                  busy,
  output logic                  done,
  output logic [ITER_WIDTH-1:0] iter_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [PC_WIDTH-1:0]   PC_ONE   = 1;
  localparam logic [ITER_WIDTH-1:0] ITER_ONE = 1;

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   max_q, loop_q, shadow;
  logic [ITER_WIDTH-1:0] iters_q, remaining, iters_sel;
  logic                  cfg_take, start_ok, end_of_pass, final_issue;
  logic                  pc_unused;

  // The PC's own output is not needed: shadow tracks its pc_next exactly.
  assign pc_unused = ^pc;

  assign cfg_take    = cfg_valid & (state == IDLE);
  assign iters_sel   = cfg_take ? cfg_iters : iters_q;
  assign start_ok    = (state == IDLE) & start & ~abort;
  assign end_of_pass = pc_en & (shadow == max_q);
  assign final_issue = end_of_pass & (remaining == ITER_ONE);

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign pc_max    = max_q;
  assign pc_loop   = loop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_en     = 1'b0;
    pc_rst    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        pc_rst = 1'b1;
        if (start_ok) state_nxt = (iters_sel != '0) ? RUN : DONE;
      end
      RUN: begin
        pc_en = ~stall & ~abort;
        if (abort)            state_nxt = IDLE;
        else if (final_issue) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = abort ? IDLE : DONE;
      DONE: begin
        pc_rst    = 1'b1;
        done      = ~abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q      <= '0;
      loop_q     <= '0;
      iters_q    <= '0;
      shadow     <= '0;
      remaining  <= '0;
      iter_count <= '0;
      pc_valid   <= 1'b0;
      last       <= 1'b0;
    end else begin
      pc_valid <= pc_en;
      last     <= final_issue;
      if (cfg_take) begin
        max_q   <= cfg_max;
        loop_q  <= (cfg_loop > cfg_max) ? cfg_max : cfg_loop;
        iters_q <= cfg_iters;
      end
      if (start_ok) begin
        shadow     <= '0;
        remaining  <= iters_sel;
        iter_count <= '0;
      end else if (pc_en) begin
        shadow <= (shadow < max_q) ? shadow + PC_ONE : loop_q;
        if (end_of_pass) begin
          iter_count <= iter_count + ITER_ONE;
          remaining  <= remaining - ITER_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_loop_sequencer.sv
// Bench for pc_loop_sequencer: emulates the attached PC, checks issued pc streams against
// a pass-list model, plus hand sequences for stall, abort and async reset.
module tb_pc_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready, start, stall, abort;
  logic [7:0]  cfg_max, cfg_loop, pc_max, pc_loop, pc;
  logic [15:0] cfg_iters, iter_count;
  logic        pc_rst, pc_en, pc_valid, last, busy, done;

  int checks = 0;
  int failures = 0;

  logic [7:0] pc_at [64];
  logic       pv_at [64];

  typedef struct {
    logic [7:0]  mx;
    logic [7:0]  lp;
    logic [15:0] it;
    logic [63:0] mask;
    int          exp_n;
    int          exp_done;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs [8];

  pc_loop_sequencer #(.PC_WIDTH(8), .ITER_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_max(cfg_max), .cfg_loop(cfg_loop), .cfg_iters(cfg_iters),
    .start(start), .stall(stall), .abort(abort), .pc_rst(pc_rst), .pc_en(pc_en),
    .pc_max(pc_max), .pc_loop(pc_loop), .pc(pc), .pc_valid(pc_valid), .last(last),
    .busy(busy), .done(done), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // attached program counter: pc takes pc_next on enable, pc_next wraps max -> loop
  logic [7:0] pc_next_m;
  always @(posedge clk or posedge rst) begin
    if (rst || pc_rst) begin
      pc        <= 8'd0;
      pc_next_m <= 8'd0;
    end else if (pc_en) begin
      pc        <= pc_next_m;
      pc_next_m <= (pc_next_m < pc_max) ? pc_next_m + 8'd1 : pc_loop;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cfg(input logic [7:0] mx, input logic [7:0] lp, input logic [15:0] it,
                         input logic [63:0] mask, input int stall_pct, input string tag,
                         output int n_valid, output int done_cyc, output logic [7:0] last_val);
    logic [7:0] exp_q[$];
    logic [7:0] first;
    int n, issued, c_final, done_cnt, idx, last_cnt, last_idx, exp_done;
    logic [15:0] itc;
    bit stream_ok, ready_ok;
    exp_q = {};
    for (int p = 0; p < int'(it); p++) begin
      first = (p == 0) ? 8'd0 : ((lp > mx) ? mx : lp);
      for (int v = int'(first); v <= int'(mx); v++) exp_q.push_back(8'(v));
    end
    n = exp_q.size();
    issued = 0; c_final = -1; done_cnt = 0; idx = 0; last_cnt = 0; last_idx = -1;
    stream_ok = 1; ready_ok = 0; done_cyc = -1; itc = '1; last_val = 8'hxx;
    cfg_valid = 1; cfg_max = mx; cfg_loop = lp; cfg_iters = it; start = 1; stall = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0)
        stall = ((cyc < 64) ? mask[cyc] : 1'b0) | (int'($urandom_range(0, 99)) < stall_pct);
      if (cyc >= 1 && !stall && issued < n) begin
        issued++;
        if (issued == n) c_final = cyc;
      end
      @(negedge clk);
      if (cyc < 64) begin pc_at[cyc] = pc; pv_at[cyc] = pc_valid; end
      if (pc_valid) begin
        if (idx >= n || pc !== exp_q[idx]) stream_ok = 0;
        if (last) begin last_cnt++; last_idx = idx; last_val = pc; end
        idx++;
      end else if (last) last_cnt += 100;
      if (done) begin done_cnt++; done_cyc = cyc; itc = iter_count; end
      step();
      cfg_valid = 0; start = 0; stall = 0;
      if (done_cyc >= 0) begin ready_ok = cfg_ready; break; end
    end
    exp_done = (n == 0) ? 1 : c_final + 2;
    n_valid = idx;
    chk({tag, " stream"}, {31'd0, stream_ok && idx == n}, 32'd1);
    chk({tag, " last_pos"}, (n == 0) ? last_cnt : ((last_cnt == 1) ? last_idx : -1), (n == 0) ? 0 : n - 1);
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " iter_count"}, {16'd0, itc}, {16'd0, it});
    chk({tag, " ready_after"}, {31'd0, ready_ok}, 32'd1);
    repeat (2) step();
    chk({tag, " one_done"}, done_cnt, 1);
  endtask

  initial begin
    int nv, dc;
    logic [7:0] lv;
    vecs[0] = '{8'd3, 8'd1, 16'd3, 64'h0,  10, 12, 8'd3};
    vecs[1] = '{8'd3, 8'd1, 16'd3, 64'h18, 10, 14, 8'd3};
    vecs[2] = '{8'd3, 8'd1, 16'd0, 64'h0,  0,  1,  8'd0};
    vecs[3] = '{8'd5, 8'd7, 16'd2, 64'h0,  7,  9,  8'd5};
    vecs[4] = '{8'd1, 8'd0, 16'd2, 64'h0,  4,  6,  8'd1};
    vecs[5] = '{8'd0, 8'd0, 16'd4, 64'h0,  4,  6,  8'd0};
    vecs[6] = '{8'd4, 8'd4, 16'd3, 64'h0,  7,  9,  8'd4};
    vecs[7] = '{8'd2, 8'd0, 16'd1, 64'h0,  3,  5,  8'd2};

    rst = 1; cfg_valid = 0; cfg_max = 0; cfg_loop = 0; cfg_iters = 0;
    start = 0; stall = 0; abort = 0;
    #2;
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst cfg_ready", {31'd0, cfg_ready}, 1);
    chk("rst pc_rst", {31'd0, pc_rst}, 1);
    chk("rst pc_en", {31'd0, pc_en}, 0);
    chk("rst pc_valid", {31'd0, pc_valid}, 0);
    chk("rst done", {31'd0, done}, 0);
    chk("rst iter_count", {16'd0, iter_count}, 0);
    chk("rst pc_max", {24'd0, pc_max}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_cfg(vecs[i].mx, vecs[i].lp, vecs[i].it, vecs[i].mask, 0, $sformatf("vec%0d", i), nv, dc, lv);
      chk($sformatf("vec%0d n_valid", i), nv, vecs[i].exp_n);
      chk($sformatf("vec%0d done_at", i), dc, vecs[i].exp_done);
      if (vecs[i].exp_n > 0) chk($sformatf("vec%0d last_val", i), {24'd0, lv}, {24'd0, vecs[i].exp_last});
      if (i == 1) begin
        chk("stall pv4", {31'd0, pv_at[4]}, 0);
        chk("stall pv5", {31'd0, pv_at[5]}, 0);
        chk("stall pc4 held", {24'd0, pc_at[4]}, {24'd0, pc_at[3]});
        chk("stall pc5 held", {24'd0, pc_at[5]}, 32'd1);
      end
      if (i == 3) chk("clamped loop", {24'd0, pc_loop}, 32'd5);
    end

    for (int r = 0; r < 20; r++)
      run_cfg(8'($urandom_range(0, 7)), 8'($urandom_range(0, 9)), 16'($urandom_range(0, 4)),
              64'h0, 25, $sformatf("rnd%0d", r), nv, dc, lv);

    // abort in IDLE beats start
    cfg_valid = 1; cfg_max = 3; cfg_loop = 1; cfg_iters = 3; start = 1; abort = 1;
    step();
    cfg_valid = 0; start = 0; abort = 0;
    chk("idle abort busy", {31'd0, busy}, 0);
    step();

    // abort during second pass
    cfg_valid = 1; start = 1;
    step();
    cfg_valid = 0; start = 0;
    repeat (5) step();
    chk("abort pre pc_en", {31'd0, pc_en}, 1);
    abort = 1;
    #1;
    chk("abort pc_en", {31'd0, pc_en}, 0);
    chk("abort done", {31'd0, done}, 0);
    step();
    abort = 0;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort pc_rst", {31'd0, pc_rst}, 1);
    chk("abort pc_valid", {31'd0, pc_valid}, 0);
    chk("abort iter_count", {16'd0, iter_count}, 1);
    step();
    chk("abort pc zero", {24'd0, pc}, 0);
    begin
      int dseen = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (done) dseen++;
      end
      chk("abort no done", dseen, 0);
    end
    step();

    // async reset mid-run
    cfg_valid = 1; cfg_max = 1; cfg_loop = 0; cfg_iters = 2; start = 1;
    step();
    cfg_valid = 0; start = 0;
    step(); step();
    chk("pre rst pc_valid", {31'd0, pc_valid}, 1);
    #2 rst = 1;
    #1;
    chk("arst pc_en", {31'd0, pc_en}, 0);
    chk("arst pc_valid", {31'd0, pc_valid}, 0);
    chk("arst busy", {31'd0, busy}, 0);
    chk("arst iter_count", {16'd0, iter_count}, 0);
    chk("arst last", {31'd0, last}, 0);
    chk("arst done", {31'd0, done}, 0);
    step();
    #2 rst = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
